// File: rtl/lte_dl_tdl_test_sched_pkg.sv
// Shared definitions for the DL TDL test scheduler: table entry layout,
// FSM state encoding and the work-mode (test disabled) output values.
package lte_dl_tdl_test_sched_pkg;

    localparam int ENTRY_W   = 44;
    localparam int SEL_LSB   = 40;
    localparam int SEL_W     = 4;
    localparam int START_LSB = 24;
    localparam int START_W   = 16;
    localparam int END_LSB   = 8;
    localparam int END_W     = 16;
    localparam int REP_LSB   = 0;
    localparam int REP_W     = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [SEL_W-1:0]   WORK_SEL = '0;
    localparam logic               WORK_VAL = 1'b0;
    localparam logic [START_W-1:0] WORK_WIN = '0;

    // A zero repeat count would stall the table, so it holds for one frame.
    function automatic logic [REP_W-1:0] eff_rep(input logic [REP_W-1:0] rep);
        return (rep == '0) ? REP_W'(1) : rep;
    endfunction

endpackage

// File: rtl/lte_dl_tdl_test_sched_if.sv
// Host-side register interface of the DL TDL test scheduler:
// table writes, sequence control and status.
interface lte_dl_tdl_test_sched_if
    import lte_dl_tdl_test_sched_pkg::*;
#(
    parameter int P_AW = 3
);
    logic               i_cfg_wr;
    logic [P_AW-1:0]    i_cfg_addr;
    logic [ENTRY_W-1:0] i_cfg_wdata;
    logic               i_start;
    logic               i_stop;
    logic               i_loop;
    logic [P_AW:0]      i_num_entry;
    logic [P_AW-1:0]    o_entry_idx;
    logic [REP_W-1:0]   o_rep_left;
    logic               o_busy;
    logic               o_done;
    logic               o_cfg_err;
    logic               o_frame_err;

    modport master (
        output i_cfg_wr, i_cfg_addr, i_cfg_wdata, i_start, i_stop, i_loop, i_num_entry,
        input  o_entry_idx, o_rep_left, o_busy, o_done, o_cfg_err, o_frame_err
    );

    modport slave (
        input  i_cfg_wr, i_cfg_addr, i_cfg_wdata, i_start, i_stop, i_loop, i_num_entry,
        output o_entry_idx, o_rep_left, o_busy, o_done, o_cfg_err, o_frame_err
    );

endinterface

// File: rtl/lte_tdl_sched_tbl.sv
// Test entry table: register file with one synchronous write port and
// one combinational read port, cleared by reset.
module lte_tdl_sched_tbl
    import lte_dl_tdl_test_sched_pkg::*;
#(
    parameter int P_DEPTH = 8,
    parameter int P_AW    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_wr,
    input  logic [P_AW-1:0]    i_waddr,
    input  logic [ENTRY_W-1:0] i_wdata,
    input  logic [P_AW-1:0]    i_raddr,
    output logic [ENTRY_W-1:0] o_rdata
);

    logic [ENTRY_W-1:0] mem_q [P_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (i_wr) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/lte_dl_tdl_test_sched.sv
// Frame-synchronous scheduler stepping through the test entry table and
// driving the TDL test-data control registers only at frame heads.
module lte_dl_tdl_test_sched
    import lte_dl_tdl_test_sched_pkg::*;
#(
    parameter int          P_DEPTH    = 8,
    parameter int          P_AW       = 3,
    parameter logic [23:0] P_FRAME_TO = 24'd2457700
) (
    input  logic                   clk_245,
    input  logic                   asy_rst_n,
    input  logic                   i_fram_hd,
    lte_dl_tdl_test_sched_if.slave host,
    output logic [SEL_W-1:0]       o_sim_tdl_sel,
    output logic                   o_tdl_test_val,
    output logic [31:0]            o_tdl_data_start,
    output logic [31:0]            o_tdl_data_end
);

    localparam logic [P_AW:0] L_DEPTH = (P_AW+1)'(P_DEPTH);
    localparam logic [P_AW:0] L_ONE   = (P_AW+1)'(1);

    state_t             state_q, state_d;
    logic [P_AW-1:0]    idx_q, idx_d;
    logic [REP_W-1:0]   rep_left_q, rep_left_d;
    logic [P_AW:0]      num_q, num_d;
    logic               stop_pend_q, stop_pend_d;
    logic [23:0]        wd_q, wd_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               val_q, val_d;
    logic [START_W-1:0] start_q, start_d;
    logic [END_W-1:0]   end_q, end_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cfg_err_q, cfg_err_d;
    logic               frame_err_q, frame_err_d;

    logic               advance;
    logic               do_load;
    logic               do_work;
    logic [P_AW-1:0]    raddr;
    logic [ENTRY_W-1:0] rdata;

    lte_tdl_sched_tbl #(
        .P_DEPTH (P_DEPTH),
        .P_AW    (P_AW)
    ) u_tbl (
        .clk     (clk_245),
        .rst_n   (asy_rst_n),
        .i_wr    (host.i_cfg_wr),
        .i_waddr (host.i_cfg_addr),
        .i_wdata (host.i_cfg_wdata),
        .i_raddr (raddr),
        .o_rdata (rdata)
    );

    // The read port always points at the entry the next frame head would load.
    assign advance = ({1'b0, idx_q} + L_ONE) < num_q;
    assign raddr   = (state_q == S_RUN && advance) ? idx_q + P_AW'(1) : '0;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rep_left_d  = rep_left_q;
        num_d       = num_q;
        stop_pend_d = stop_pend_q;
        wd_d        = '0;
        sel_d       = sel_q;
        val_d       = val_q;
        start_d     = start_q;
        end_d       = end_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;
        frame_err_d = frame_err_q;
        do_load     = 1'b0;
        do_work     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (host.i_start && !host.i_stop) begin
                    if (host.i_num_entry == '0 || host.i_num_entry > L_DEPTH) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b0;
                        num_d       = host.i_num_entry;
                        stop_pend_d = 1'b0;
                        state_d     = S_ARM;
                    end
                end
            end
            S_ARM: begin
                if (host.i_stop) begin
                    state_d = S_IDLE;
                end else if (i_fram_hd) begin
                    do_load = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (i_fram_hd) begin
                    if (stop_pend_q || host.i_stop) begin
                        do_work = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (rep_left_q > REP_W'(1)) begin
                        rep_left_d = rep_left_q - REP_W'(1);
                    end else if (advance || host.i_loop) begin
                        do_load = 1'b1;
                    end else begin
                        do_work = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else if (host.i_stop) begin
                    stop_pend_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Watchdog: a frame head in the expiry cycle keeps the sequence alive.
        if ((state_q == S_ARM || state_q == S_RUN) && !i_fram_hd) begin
            if (wd_q == P_FRAME_TO - 24'd1) begin
                frame_err_d = 1'b1;
                stop_pend_d = 1'b0;
                do_work     = 1'b1;
                state_d     = S_IDLE;
            end else begin
                wd_d = wd_q + 24'd1;
            end
        end

        if (do_load) begin
            idx_d      = raddr;
            sel_d      = rdata[SEL_LSB +: SEL_W];
            start_d    = rdata[START_LSB +: START_W];
            end_d      = rdata[END_LSB +: END_W];
            rep_left_d = eff_rep(rdata[REP_LSB +: REP_W]);
            val_d      = 1'b1;
        end
        if (do_work) begin
            sel_d   = WORK_SEL;
            val_d   = WORK_VAL;
            start_d = WORK_WIN;
            end_d   = WORK_WIN;
        end

        busy_d = (state_d == S_ARM) || (state_d == S_RUN);
    end

    always_ff @(posedge clk_245 or negedge asy_rst_n) begin
        if (!asy_rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            rep_left_q  <= '0;
            num_q       <= '0;
            stop_pend_q <= 1'b0;
            wd_q        <= '0;
            sel_q       <= '0;
            val_q       <= 1'b0;
            start_q     <= '0;
            end_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rep_left_q  <= rep_left_d;
            num_q       <= num_d;
            stop_pend_q <= stop_pend_d;
            wd_q        <= wd_d;
            sel_q       <= sel_d;
            val_q       <= val_d;
            start_q     <= start_d;
            end_q       <= end_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign o_sim_tdl_sel    = sel_q;
    assign o_tdl_test_val   = val_q;
    assign o_tdl_data_start = {16'd0, start_q};
    assign o_tdl_data_end   = {16'd0, end_q};
    assign host.o_entry_idx = idx_q;
    assign host.o_rep_left  = rep_left_q;
    assign host.o_busy      = busy_q;
    assign host.o_done      = done_q;
    assign host.o_cfg_err   = cfg_err_q;
    assign host.o_frame_err = frame_err_q;

endmodule
